// File: rtl/sipo_frame_ctrl_if.sv
// rtl/sipo_frame_ctrl_if.sv - serial source / parallel consumer bundle for sipo_frame_ctrl
interface sipo_frame_ctrl_if #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
);
    logic             start;
    logic             din;
    logic             din_vld;
    logic             data_rdy;
    logic             sh_en;
    logic [WIDTH-1:0] data_out;
    logic             data_vld;
    logic             busy;
    logic [CNT_W-1:0] bit_cnt;
    logic             overrun;
    logic             parity_err;

    modport master (
        output start, din, din_vld, data_rdy,
        input  sh_en, data_out, data_vld, busy, bit_cnt, overrun, parity_err
    );

    modport slave (
        input  start, din, din_vld, data_rdy,
        output sh_en, data_out, data_vld, busy, bit_cnt, overrun, parity_err
    );
endinterface

// File: rtl/sipo_frame_ctrl.sv
// rtl/sipo_frame_ctrl.sv - serial-in parallel-out frame controller; optional SIPO_PARITY_EN adds a trailing even-parity bit
module sipo_frame_ctrl #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
) (
    input  logic               clk,
    input  logic               rst,
    sipo_frame_ctrl_if.slave   bus
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

`ifdef SIPO_PARITY_EN
    localparam int LAST = WIDTH;
`else
    localparam int LAST = WIDTH - 1;
`endif

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] word;
    logic [CNT_W-1:0] bit_cnt_q;
    logic             data_vld_q;
    logic             overrun_q;
    logic             in_shift;
    logic             done;
    logic             free;
`ifdef SIPO_PARITY_EN
    logic             par_bit_q;
    logic             parity_err_q;
    logic             data_bit;
`endif

    always_comb begin
        in_shift = bus.din_vld && (state == S_SHIFT);
        done     = in_shift && (bit_cnt_q == CNT_W'(LAST));
        free     = !data_vld_q || bus.data_rdy;
`ifdef SIPO_PARITY_EN
        // the parity bit is the only one counted past WIDTH-1 and never enters shreg
        data_bit = (bit_cnt_q != CNT_W'(WIDTH));
        word     = shreg;
`else
        word     = {shreg[WIDTH-2:0], bus.din};
`endif
    end

`ifdef SIPO_PARITY_EN
    assign bus.sh_en      = in_shift && data_bit;
    assign bus.parity_err = parity_err_q;
`else
    assign bus.sh_en      = in_shift;
    assign bus.parity_err = 1'b0;
`endif
    assign bus.data_out = data_q;
    assign bus.data_vld = data_vld_q;
    assign bus.busy     = (state != S_IDLE);
    assign bus.bit_cnt  = bit_cnt_q;
    assign bus.overrun  = overrun_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            shreg      <= '0;
            data_q     <= '0;
            bit_cnt_q  <= '0;
            data_vld_q <= 1'b0;
            overrun_q  <= 1'b0;
`ifdef SIPO_PARITY_EN
            par_bit_q    <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            // a reload below overrides this consume-clear
            if (data_vld_q && bus.data_rdy)
                data_vld_q <= 1'b0;
            if (bus.sh_en)
                shreg <= {shreg[WIDTH-2:0], bus.din};

            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        state     <= S_SHIFT;
                        bit_cnt_q <= '0;
                    end
                end
                S_SHIFT: begin
                    if (done) begin
                        bit_cnt_q <= '0;
                        if (free) begin
                            data_q     <= word;
                            data_vld_q <= 1'b1;
`ifdef SIPO_PARITY_EN
                            parity_err_q <= ^{word, bus.din};
`endif
                            state <= bus.start ? S_SHIFT : S_IDLE;
                        end else begin
                            shreg <= word;
`ifdef SIPO_PARITY_EN
                            par_bit_q <= bus.din;
`endif
                            state <= S_WAIT;
                        end
                    end else if (bus.din_vld) begin
                        bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                    end
                end
                S_WAIT: begin
                    if (bus.din_vld)
                        overrun_q <= 1'b1;
                    if (bus.data_rdy) begin
                        data_q     <= shreg;
                        data_vld_q <= 1'b1;
`ifdef SIPO_PARITY_EN
                        parity_err_q <= ^{shreg, par_bit_q};
`endif
                        state <= bus.start ? S_SHIFT : S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: doc/sipo_frame_ctrl.md
Name: sipo_frame_ctrl

Overview:
- Controller that sequences a serial-in parallel-out shift path.
- Accepts a strobed serial bit stream and counts WIDTH bits per frame.
- Drives a shift-enable for the shift stage, which it also contains internally.
- Transfers each completed word into an output holding register with a valid/ready handshake.
- Sits between a serial source and a parallel consumer.
- Applies backpressure by stalling in a wait state and flags bits dropped while stalled.

Parameters:
- WIDTH, 4, number of data bits per frame (≥2).
- CNT_W, 3, width of bit counter; must satisfy 2**CNT_W > WIDTH.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a frame; sampled only in IDLE, or at word completion.
- din  in  1  serial data bit.
- din_vld  in  1  din qualifier; one bit is consumed per cycle it is high in SHIFT.
- data_rdy  in  1  consumer accepts data_out when data_vld & data_rdy.
- sh_en  out  1  shift enable to shift stage; combinational = din_vld & (state==SHIFT).
- data_out  out  WIDTH  assembled word (holding register).
- data_vld  out  1  holding register full.
- busy  out  1  state != IDLE.
- bit_cnt  out  CNT_W  bits received in current frame.
- overrun  out  1  sticky: a din_vld bit arrived in WAIT and was dropped.
- parity_err  out  1  see Optional Feature.

Behaviour:
- Reset (rst=1 at clk edge):
  - state=IDLE; shreg, data_out, bit_cnt = 0.
  - data_vld, overrun, parity_err = 0.
  - Reset mid-frame discards the partial word.
- Shift rule:
  - When sh_en=1: shreg <= {shreg[WIDTH-2:0], din}.
  - The first bit received ends in the MSB.
- States:
  - IDLE:
    - din_vld ignored, no shift.
    - start=1 -> SHIFT with bit_cnt=0.
  - SHIFT:
    - Each din_vld cycle: shift, bit_cnt++.
    - Word completion is a din_vld cycle with bit_cnt==WIDTH-1. On completion, bit_cnt <= 0 and the word is {shreg[WIDTH-2:0], din}.
    - If holding register is free (data_vld==0, or data_vld & data_rdy this cycle): data_out <= word, data_vld <= 1. Next state is SHIFT if start=1 that cycle, else IDLE.
    - Otherwise: shreg <= word, next state WAIT.
  - WAIT:
    - sh_en=0.
    - Any din_vld=1 sets overrun; the bit is dropped.
    - When data_rdy=1: data_out <= shreg, data_vld stays 1. Next state is SHIFT if start=1 that cycle, else IDLE.
- Timing:
  - Final bit at edge N -> data_vld=1 and data_out valid after edge N (visible cycle N+1).
  - Back-to-back frames at full din_vld rate lose no bits when the consumer holds data_rdy=1.
- Handshake:
  - data_vld clears after a cycle with data_vld & data_rdy, unless reloaded in the same cycle; reload takes priority.
  - data_out is stable while data_vld=1 and data_rdy=0.
- start in SHIFT or WAIT, other than at completion/exit, is ignored; no restart mid-frame.
- bit_cnt never exceeds WIDTH-1, or WIDTH with parity enabled.
- overrun clears only on rst.

Optional Feature:
- Macro SIPO_PARITY_EN.
- Defined:
  - Each frame carries one extra even-parity bit after the WIDTH data bits.
  - Completion occurs on the bit with bit_cnt==WIDTH.
  - The parity bit is not shifted into shreg; sh_en stays low for it.
  - parity_err is loaded together with data_out: 1 if XOR(data, parity bit)=1.
- Not defined:
  - parity_err is tied to 0.
  - Frames are exactly WIDTH bits.

Test Plan (WIDTH=4):
- Reset then idle: rst=1 one cycle; din_vld toggling without start -> data_vld=0, bit_cnt=0, busy=0, sh_en=0.
- Single frame: start pulse, then din=1,0,1,1 with din_vld=1 on 4 consecutive cycles, data_rdy=1 -> data_out=4'b1011, data_vld=1 for exactly one cycle starting the cycle after the 4th bit; returns to IDLE.
- Gapped strobe: bits 1,1,0,0 with din_vld low between bits -> bit_cnt increments only on strobes; data_out=4'b1100.
- Backpressure: data_rdy=0 with word 4'b0110 held; second frame 4'b1001 completes -> WAIT, busy=1; a din_vld in WAIT sets overrun=1; then data_rdy=1 -> 0110 accepted, data_out=1001, data_vld stays 1.
- Continuous: start held high, 8 bits 1010_0101 back-to-back, data_rdy=1 -> words 1010 then 0101, no dropped bits, overrun=0.
- Mid-frame reset: after 2 bits assert rst -> state IDLE, bit_cnt=0, shreg=0; a following clean frame 4'b0011 is received correctly. With SIPO_PARITY_EN: data 1011 + parity 1 -> parity_err=0; parity 0 -> parity_err=1.
